demodulator: RTL

DEMODULATOR -- requirements
Module: Demodulator

---
 rtl/demodulator.sv | 110 +++++++++++
 1 files changed

// File: rtl/demodulator.sv
// Recovers 2-bit phase symbols from a 4-phase square-wave carrier
// by timing its rising edges against a free-running local counter.
module demodulator #(
    parameter int FREQ_DIV = 128,
    parameter int EDGE_OFS = 2,
    parameter int CONFIRM  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic [1:0] dout,
    output logic       valid,
    output logic       sym_stb,
    output logic       err
);
    localparam int CW = $clog2(FREQ_DIV);
    localparam int GW = CW + 2;
    localparam int OFS_I =
        ((FREQ_DIV / 8 - EDGE_OFS) % FREQ_DIV + FREQ_DIV) % FREQ_DIV;
    localparam logic [CW-1:0] PH_OFS  = CW'(OFS_I);
    localparam logic [GW-1:0] GAP_MAX = GW'(2 * FREQ_DIV);
    localparam logic [GW-1:0] GAP_MIN = GW'(FREQ_DIV / 2);
    localparam logic [2:0]    CONF    = 3'(CONFIRM);

    typedef enum logic [1:0] {
        NO_CARRIER,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gap, gap_n;
    logic          d1, d2;
    logic          rise;
    logic [CW-1:0] phase;
    logic [1:0]    raw;
    logic [1:0]    cand, cand_n;
    logic [2:0]    match, match_n;
    logic [1:0]    dout_n;
    logic          stb_n, err_n;

    assign rise = d1 & ~d2;

    // Quarter-period windows centred on each nominal edge position;
    // modulo arithmetic comes for free from the CW-bit wrap.
    assign phase = cnt + PH_OFS;
    assign raw   = 2'(phase >> (CW - 2));

    always_comb begin
        state_n = state;
        cand_n  = cand;
        match_n = match;
        dout_n  = dout;
        stb_n   = 1'b0;
        err_n   = 1'b0;
        gap_n   = (gap == GAP_MAX) ? gap : gap + GW'(1);
        if (rise && state != NO_CARRIER && gap < GAP_MIN) begin
            err_n = 1'b1;
        end else if (rise) begin
            gap_n = '0;
            if (state != NO_CARRIER && raw == cand) begin
                if (match != CONF)
                    match_n = match + 3'd1;
            end else begin
                cand_n  = raw;
                match_n = 3'd1;
            end
            if (state == NO_CARRIER)
                state_n = ACQUIRE;
            if (match_n == CONF &&
                (state != LOCKED || cand_n != dout)) begin
                dout_n  = cand_n;
                stb_n   = 1'b1;
                state_n = LOCKED;
            end
        end else if (gap == GAP_MAX) begin
            state_n = NO_CARRIER;
            match_n = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            gap     <= '0;
            d1      <= 1'b0;
            d2      <= 1'b0;
            cand    <= 2'b00;
            match   <= '0;
            state   <= NO_CARRIER;
            dout    <= 2'b00;
            valid   <= 1'b0;
            sym_stb <= 1'b0;
            err     <= 1'b0;
        end else begin
            cnt     <= cnt + CW'(1);
            d1      <= din;
            d2      <= d1;
            gap     <= gap_n;
            cand    <= cand_n;
            match   <= match_n;
            state   <= state_n;
            dout    <= dout_n;
            valid   <= (state_n == LOCKED);
            sym_stb <= stb_n;
            err     <= err_n;
        end
    end
endmodule
